// File: rtl/nbdcache_mshr_file.sv
`default_nettype none
// ============================================================================
// Module   : nbdcache_mshr_file
// Purpose  : Multi-entry miss-status holding register file for the
//            non-blocking L1 data cache. NR_PORTS cache controllers share
//            NR_MSHR outstanding line misses. Entries are allocated one per
//            cycle under round-robin arbitration, issued to the miss handler
//            in allocation order, and freed by the miss handler's done
//            report.
// Ports    : clk_i/rst_i              clock, synchronous active-high reset
//            alloc_req/addr/we_i      per-port miss allocation requests
//            alloc_gnt_o/alloc_id_o   one-hot grant and allocated entry id
//            issue_*                  head-of-order entry to the miss handler
//            done_valid_i/done_id_i   refill completion for an ISSUED entry
//            lookup_addr_i            per-port probe address
//            addr_match_o/index_match_o  probe hits a live line / index
//            full_o/busy_o            no free entry / some live entry
// Revision : 1.0 - initial release
// ============================================================================
module nbdcache_mshr_file #(
  parameter int NR_PORTS    = 3,
  parameter int NR_MSHR     = 4,
  parameter int ADDR_WIDTH  = 56,
  parameter int INDEX_WIDTH = 12,
  parameter int BYTE_OFFSET = 4,
  parameter int ID_WIDTH    = $clog2(NR_MSHR)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_PORTS-1:0]            alloc_req_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic [NR_PORTS-1:0]            alloc_we_i,
  output logic [NR_PORTS-1:0]            alloc_gnt_o,
  output logic [ID_WIDTH-1:0]            alloc_id_o,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [ADDR_WIDTH-1:0]          issue_addr_o,
  output logic                           issue_we_o,
  output logic [ID_WIDTH-1:0]            issue_id_o,
  input  logic                           done_valid_i,
  input  logic [ID_WIDTH-1:0]            done_id_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NR_PORTS-1:0]            addr_match_o,
  output logic [NR_PORTS-1:0]            index_match_o,
  output logic                           full_o,
  output logic                           busy_o
);

  localparam int c_line_w = ADDR_WIDTH - BYTE_OFFSET;
  localparam int c_idx_w  = INDEX_WIDTH - BYTE_OFFSET;
  localparam int c_rr_w   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_FREE       = 2'd0,
    ST_WAIT_ISSUE = 2'd1,
    ST_ISSUED     = 2'd2
  } entry_state_e;

  entry_state_e        r_state [NR_MSHR];
  logic [c_line_w-1:0] r_line  [NR_MSHR];
  logic [NR_MSHR-1:0]  r_we;
  logic [ID_WIDTH-1:0] r_fifo  [NR_MSHR];
  // One extra wrap bit on each pointer separates empty from full.
  logic [ID_WIDTH:0]   r_head;
  logic [ID_WIDTH:0]   r_tail;
  logic [c_rr_w-1:0]   r_rr;

  logic [NR_MSHR-1:0]  w_used;
  logic [NR_PORTS-1:0] w_elig;
  logic [c_line_w-1:0] w_port_line [NR_PORTS];
  logic [NR_PORTS-1:0] w_unused_bits;
  logic                w_grant;
  logic [c_rr_w-1:0]   w_gnt_port;
  logic [ID_WIDTH-1:0] w_free_id;
  logic [ID_WIDTH-1:0] w_head_id;
  logic                w_pop;

  generate
    for (genvar i = 0; i < NR_MSHR; i++) begin : g_used
      assign w_used[i] = (r_state[i] != ST_FREE);
    end
  endgenerate

  assign full_o = &w_used;
  assign busy_o = |w_used;

  // Per-port comparators: allocation eligibility plus the probe matches.
  generate
    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
      logic [c_line_w-1:0] w_look_line;
      logic [NR_MSHR-1:0]  w_alloc_hit;
      logic [NR_MSHR-1:0]  w_addr_hit;
      logic [NR_MSHR-1:0]  w_idx_hit;

      assign w_port_line[p] = alloc_addr_i[p*ADDR_WIDTH+BYTE_OFFSET +: c_line_w];
      assign w_look_line    = lookup_addr_i[p*ADDR_WIDTH+BYTE_OFFSET +: c_line_w];

      for (genvar i = 0; i < NR_MSHR; i++) begin : g_cmp
        assign w_alloc_hit[i] = w_used[i] && (r_line[i] == w_port_line[p]);
        assign w_addr_hit[i]  = w_used[i] && (r_line[i] == w_look_line);
        assign w_idx_hit[i]   = w_used[i] &&
                                (r_line[i][c_idx_w-1:0] == w_look_line[c_idx_w-1:0]);
      end

      // A second miss to a line already in flight would double-refill it.
      assign w_elig[p]        = alloc_req_i[p] && !(|w_alloc_hit);
      assign addr_match_o[p]  = |w_addr_hit;
      assign index_match_o[p] = |w_idx_hit;
      assign w_unused_bits[p] = ^{alloc_addr_i[p*ADDR_WIDTH +: BYTE_OFFSET],
                                  lookup_addr_i[p*ADDR_WIDTH +: BYTE_OFFSET]};
    end
  endgenerate

  // Round-robin search starting at r_rr (the port after the last grant).
  always_comb begin : b_arb
    int p;
    p          = 0;
    w_grant    = 1'b0;
    w_gnt_port = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      p = (int'(r_rr) + k) % NR_PORTS;
      if (!w_grant && w_elig[c_rr_w'(p)]) begin
        w_grant    = 1'b1;
        w_gnt_port = c_rr_w'(p);
      end
    end
    // Full is judged on pre-edge state; a same-cycle done does not help.
    if (full_o) begin
      w_grant = 1'b0;
    end
  end

  always_comb begin
    alloc_gnt_o             = '0;
    alloc_gnt_o[w_gnt_port] = w_grant;
  end

  // Lowest-index free entry (descending scan so the lowest wins).
  always_comb begin
    w_free_id = '0;
    for (int i = NR_MSHR - 1; i >= 0; i--) begin
      if (!w_used[i]) begin
        w_free_id = ID_WIDTH'(i);
      end
    end
  end

  assign alloc_id_o = w_grant ? w_free_id : '0;

  assign issue_valid_o = (r_head != r_tail);
  assign w_head_id     = r_fifo[r_head[ID_WIDTH-1:0]];
  assign issue_id_o    = issue_valid_o ? w_head_id : '0;
  assign issue_we_o    = issue_valid_o & r_we[w_head_id];
  assign issue_addr_o  = issue_valid_o ? {r_line[w_head_id], {BYTE_OFFSET{1'b0}}} : '0;
  assign w_pop         = issue_valid_o && issue_ready_i;

  // Done, issue and allocate touch entries in disjoint states (ISSUED,
  // WAIT_ISSUE, FREE), so all three may land on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_MSHR; i++) begin
        r_state[i] <= ST_FREE;
        r_line[i]  <= '0;
        r_fifo[i]  <= '0;
      end
      r_we   <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_rr   <= '0;
    end else begin
      if (done_valid_i && (r_state[done_id_i] == ST_ISSUED)) begin
        r_state[done_id_i] <= ST_FREE;
      end
      if (w_pop) begin
        r_state[w_head_id] <= ST_ISSUED;
        r_head             <= r_head + 1'b1;
      end
      if (w_grant) begin
        r_state[w_free_id]           <= ST_WAIT_ISSUE;
        r_line[w_free_id]            <= w_port_line[w_gnt_port];
        r_we[w_free_id]              <= alloc_we_i[w_gnt_port];
        r_fifo[r_tail[ID_WIDTH-1:0]] <= w_free_id;
        r_tail                       <= r_tail + 1'b1;
        r_rr <= (w_gnt_port == c_rr_w'(NR_PORTS - 1)) ? '0 : w_gnt_port + 1'b1;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^w_unused_bits;

  // A done for an entry that was never issued is dropped by the logic above.
  a_done_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    done_valid_i |-> (r_state[done_id_i] == ST_ISSUED))
    else $error("done_valid_i for an entry that is not ISSUED");

endmodule
`default_nettype wire

// File: tb/tb_nbdcache_mshr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbdcache_mshr_file
// Purpose  : Self-checking bench for nbdcache_mshr_file. Keeps a queue-based
//            reference model of entry states and allocation order, and
//            compares the DUT against directed constants and the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbdcache_mshr_file;

  localparam int AW = 56;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] we = '0;
  logic [AW-1:0] a_addr [3];
  logic [AW-1:0] l_addr [3];
  logic [3*AW-1:0] alloc_addr;
  logic [3*AW-1:0] lookup_addr;
  logic ready = 1'b0;
  logic done_valid = 1'b0;
  logic [1:0] done_id = '0;

  logic [2:0] gnt;
  logic [1:0] aid;
  logic iv;
  logic [AW-1:0] iaddr;
  logic iwe;
  logic [1:0] iid;
  logic [2:0] amatch;
  logic [2:0] imatch;
  logic full;
  logic busy;

  assign alloc_addr  = {a_addr[2], a_addr[1], a_addr[0]};
  assign lookup_addr = {l_addr[2], l_addr[1], l_addr[0]};

  nbdcache_mshr_file dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_req_i  (req),
    .alloc_addr_i (alloc_addr),
    .alloc_we_i   (we),
    .alloc_gnt_o  (gnt),
    .alloc_id_o   (aid),
    .issue_valid_o(iv),
    .issue_ready_i(ready),
    .issue_addr_o (iaddr),
    .issue_we_o   (iwe),
    .issue_id_o   (iid),
    .done_valid_i (done_valid),
    .done_id_i    (done_id),
    .lookup_addr_i(lookup_addr),
    .addr_match_o (amatch),
    .index_match_o(imatch),
    .full_o       (full),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: 0 = free, 1 = waiting for issue, 2 = issued.
  int            m_state [4];
  logic [AW-1:0] m_line  [4];
  bit            m_we    [4];
  int            m_q[$];
  int            m_rr;
  int            m_last_gp;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_state[i] != 0) n++;
    return n;
  endfunction

  function automatic bit m_line_busy(logic [AW-1:0] a);
    for (int i = 0; i < 4; i++)
      if (m_state[i] != 0 && (m_line[i] >> 4) == (a >> 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_index_busy(logic [AW-1:0] a);
    for (int i = 0; i < 4; i++)
      if (m_state[i] != 0 && m_line[i][11:4] == a[11:4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_gnt_port();
    int p;
    if (m_count() == 4) return -1;
    for (int k = 0; k < 3; k++) begin
      p = (m_rr + k) % 3;
      if (req[p] && !m_line_busy(a_addr[p])) return p;
    end
    return -1;
  endfunction

  function automatic int m_free_id();
    for (int i = 0; i < 4; i++) if (m_state[i] == 0) return i;
    return 0;
  endfunction

  function automatic logic [59:0] m_issue_vec();
    if (m_q.size() == 0) return '0;
    return {1'b1, m_we[m_q[0]], 2'(m_q[0]), m_line[m_q[0]]};
  endfunction

  function automatic logic [5:0] m_match_vec();
    logic [2:0] am;
    logic [2:0] im;
    for (int p = 0; p < 3; p++) begin
      am[p] = m_line_busy(l_addr[p]);
      im[p] = m_index_busy(l_addr[p]);
    end
    return {am, im};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a        = '0;
    a[40]    = 1'($urandom_range(0, 1));
    a[13:12] = 2'($urandom_range(0, 3));
    a[6:4]   = 3'($urandom_range(0, 7));
    a[3:0]   = 4'($urandom_range(0, 15));
    return a;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic m_update();
    int gp;
    int fid;
    bit iss;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_state[i] = 0;
        m_line[i]  = '0;
        m_we[i]    = 1'b0;
      end
      m_q.delete();
      m_rr      = 0;
      m_last_gp = -1;
      return;
    end
    gp        = m_gnt_port();
    fid       = m_free_id();
    iss       = (m_q.size() > 0) && ready;
    m_last_gp = gp;
    if (done_valid && m_state[done_id] == 2) m_state[done_id] = 0;
    if (iss) begin
      m_state[m_q[0]] = 2;
      void'(m_q.pop_front());
    end
    if (gp >= 0) begin
      m_state[fid] = 1;
      m_line[fid]  = {a_addr[gp][AW-1:4], 4'h0};
      m_we[fid]    = we[gp];
      m_q.push_back(fid);
      m_rr = (gp + 1) % 3;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; ready = 1'b0; done_valid = 1'b0; done_id = '0;
    for (int p = 0; p < 3; p++) begin
      a_addr[p] = '0;
      l_addr[p] = '0;
    end
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({gnt, aid, iv, iwe, iid, iaddr, full, busy, amatch, imatch} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got gnt=%b id=%0d iv=%b addr=%h full=%b busy=%b am=%b im=%b want all 0",
               gnt, aid, iv, iaddr, full, busy, amatch, imatch);
    end
    cycle();
    req = 3'b001; a_addr[0] = 56'h1000;
    @(negedge clk);
    total++;
    if (gnt !== 3'b001 || aid !== 2'd0) begin
      bad++; $display("FAIL reset_first_grant got gnt=%b id=%0d want 001/0", gnt, aid);
    end
    cycle();
    req = '0;
    @(negedge clk);
    total++;
    if (iv !== 1'b1 || iaddr !== 56'h1000) begin
      bad++; $display("FAIL reset_first_issue got iv=%b addr=%h want 1/1000", iv, iaddr);
    end
    cycle();
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 3'b001; a_addr[0] = 56'(i + 1) << 12;
      @(negedge clk);
      total++;
      if (gnt !== 3'b001 || aid !== 2'(i)) begin
        bad++; $display("FAIL fill_grant[%0d] got gnt=%b id=%0d want 001/%0d", i, gnt, aid, i);
      end
      cycle();
    end
    req = '0;
    @(negedge clk);
    total++;
    if (full !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL fill_full got full=%b busy=%b want 1/1", full, busy);
    end
    cycle();
    req = 3'b001; a_addr[0] = 56'h5000;
    @(negedge clk);
    total++;
    if (gnt !== 3'b000 || aid !== 2'd0) begin
      bad++; $display("FAIL full_no_grant got gnt=%b id=%0d want 000/0", gnt, aid);
    end
    ready = 1'b1;
    cycle();
    ready = 1'b0; done_valid = 1'b1; done_id = 2'd0;
    @(negedge clk);
    total++;
    if (gnt !== 3'b000) begin
      bad++; $display("FAIL full_done_same_cycle got gnt=%b want 000", gnt);
    end
    cycle();
    done_valid = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 3'b001 || aid !== 2'd0) begin
      bad++; $display("FAIL full_done_next_cycle got gnt=%b id=%0d want 001/0", gnt, aid);
    end
    cycle();
    req = '0;
  endtask

  task automatic test_dup_line();
    do_reset();
    req = 3'b001; a_addr[0] = 56'h1040;
    @(negedge clk);
    cycle();
    req = 3'b110; a_addr[1] = 56'h1048; a_addr[2] = 56'h1078;
    l_addr[0] = 56'h5040; l_addr[1] = 56'h1048; l_addr[2] = 56'h0;
    @(negedge clk);
    total++;
    if (gnt !== 3'b100 || aid !== 2'd1) begin
      bad++; $display("FAIL dup_grant got gnt=%b id=%0d want 100/1", gnt, aid);
    end
    total++;
    if (amatch !== 3'b010) begin
      bad++; $display("FAIL dup_addr_match got %b want 010", amatch);
    end
    total++;
    if (imatch !== 3'b011) begin
      bad++; $display("FAIL dup_index_match got %b want 011", imatch);
    end
    cycle();
    req = '0;
  endtask

  task automatic test_round_robin();
    int nxt;
    bit iss_v;
    int iss_id;
    do_reset();
    ready = 1'b1;
    for (int p = 0; p < 3; p++) a_addr[p] = 56'h10000 + 56'(p) * 56'h100;
    nxt = 3;
    for (int n = 0; n < 9; n++) begin
      req = 3'b111;
      @(negedge clk);
      total++;
      if (gnt !== 3'(1 << (n % 3))) begin
        bad++; $display("FAIL rr_grant[%0d] got %b want %b", n, gnt, 3'(1 << (n % 3)));
      end
      iss_v  = m_q.size() > 0;
      iss_id = iss_v ? m_q[0] : 0;
      cycle();
      if (m_last_gp >= 0) begin
        a_addr[m_last_gp] = 56'h10000 + 56'(nxt) * 56'h100;
        nxt++;
      end
      done_valid = iss_v; done_id = 2'(iss_id);
    end
    req = '0; done_valid = 1'b0; ready = 1'b0;
  endtask

  task automatic test_order_completion();
    int exp_idx;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req = 3'b001; a_addr[0] = 56'(k + 1) << 12;
      cycle();
    end
    req = '0;
    exp_idx = 0;
    for (int c = 0; c < 6; c++) begin
      ready = (c % 2 == 1);
      @(negedge clk);
      total++;
      if (iv !== 1'b1 || iid !== 2'(exp_idx) || iaddr !== (56'(exp_idx + 1) << 12)) begin
        bad++; $display("FAIL order_issue[%0d] got iv=%b id=%0d addr=%h want 1/%0d/%h",
                        c, iv, iid, iaddr, exp_idx, 56'(exp_idx + 1) << 12);
      end
      cycle();
      if (ready) exp_idx++;
    end
    ready = 1'b0; l_addr[0] = 56'h3000;
    @(negedge clk);
    total++;
    if (iv !== 1'b0 || amatch[0] !== 1'b1) begin
      bad++; $display("FAIL order_drained got iv=%b am0=%b want 0/1", iv, amatch[0]);
    end
    done_valid = 1'b1; done_id = 2'd2;
    cycle();
    done_id = 2'd0;
    @(negedge clk);
    total++;
    if (amatch[0] !== 1'b0) begin
      bad++; $display("FAIL done_match_drop got am0=%b want 0", amatch[0]);
    end
    cycle();
    done_valid = 1'b0; req = 3'b001; a_addr[0] = 56'h9000;
    @(negedge clk);
    total++;
    if (gnt !== 3'b001 || aid !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL realloc_id got gnt=%b id=%0d busy=%b want 001/0/1", gnt, aid, busy);
    end
    cycle();
    req = '0;
  endtask

  task automatic test_wraparound();
    int gp;
    int iss_pick;
    do_reset();
    ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      req = 3'b001; a_addr[0] = 56'h20000 + 56'(r) * 56'h100; we[0] = r[0];
      iss_pick = -1;
      for (int i = 0; i < 4; i++) if (m_state[i] == 2 && iss_pick < 0) iss_pick = i;
      done_valid = (iss_pick >= 0); done_id = 2'((iss_pick >= 0) ? iss_pick : 0);
      @(negedge clk);
      gp = m_gnt_port();
      total++;
      if (gnt !== ((gp < 0) ? 3'b000 : 3'(1 << gp)) || aid !== ((gp < 0) ? 2'd0 : 2'(m_free_id()))) begin
        bad++; $display("FAIL wrap_alloc[%0d] got gnt=%b id=%0d want port %0d id %0d", r, gnt, aid, gp, m_free_id());
      end
      total++;
      if ({iv, iwe, iid, iaddr} !== m_issue_vec()) begin
        bad++; $display("FAIL wrap_issue[%0d] got %h want %h", r, {iv, iwe, iid, iaddr}, m_issue_vec());
      end
      cycle();
    end
    req = '0; we = '0; done_valid = 1'b0; ready = 1'b0;
  endtask

  task automatic test_random();
    bit pend [3];
    int issued[$];
    int gp;
    logic [2:0] exp_gnt;
    do_reset();
    for (int p = 0; p < 3; p++) pend[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]   = 1'b1;
          a_addr[p] = rand_addr();
          we[p]     = 1'($urandom_range(0, 1));
        end
        l_addr[p] = rand_addr();
      end
      req   = {pend[2], pend[1], pend[0]};
      ready = ($urandom_range(0, 2) != 0);
      issued.delete();
      for (int i = 0; i < 4; i++) if (m_state[i] == 2) issued.push_back(i);
      done_valid = 1'b0; done_id = '0;
      if (issued.size() > 0 && $urandom_range(0, 1) == 1) begin
        done_valid = 1'b1;
        done_id    = 2'(issued[$urandom_range(0, issued.size() - 1)]);
      end
      @(negedge clk);
      gp      = m_gnt_port();
      exp_gnt = (gp < 0) ? 3'b000 : 3'(1 << gp);
      total++;
      if (gnt !== exp_gnt) begin
        bad++; $display("FAIL rand_gnt[%0d] got %b want %b", c, gnt, exp_gnt);
      end
      total++;
      if (aid !== ((gp < 0) ? 2'd0 : 2'(m_free_id()))) begin
        bad++; $display("FAIL rand_id[%0d] got %0d want %0d", c, aid, (gp < 0) ? 0 : m_free_id());
      end
      total++;
      if ({iv, iwe, iid, iaddr} !== m_issue_vec()) begin
        bad++; $display("FAIL rand_issue[%0d] got %h want %h", c, {iv, iwe, iid, iaddr}, m_issue_vec());
      end
      total++;
      if ({full, busy} !== {m_count() == 4, m_count() > 0}) begin
        bad++; $display("FAIL rand_full_busy[%0d] got %b%b want count %0d", c, full, busy, m_count());
      end
      total++;
      if ({amatch, imatch} !== m_match_vec()) begin
        bad++; $display("FAIL rand_match[%0d] got %b want %b", c, {amatch, imatch}, m_match_vec());
      end
      cycle();
      if (m_last_gp >= 0) pend[m_last_gp] = 1'b0;
    end
    req = '0; done_valid = 1'b0; ready = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      a_addr[p] = '0;
      l_addr[p] = '0;
    end
    test_reset();
    test_fill_full();
    test_dup_line();
    test_round_robin();
    test_order_completion();
    test_wraparound();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
